// File: rtl/mant_mul_seq.sv
// Sequential 24x24 unsigned mantissa multiplier.
// A radix-2 shift-and-add loop drives one sum24bit prefix adder, one pass
// per clock. Operands arrive on a valid/ready start handshake. The 48-bit
// product leaves on a valid/ready result handshake.

// 24-bit Kogge-Stone prefix adder with a 25-bit result.
// kIn is the carry-in status code: 2'b11 generates a carry-in, and every
// other code kills it.
module sum24bit (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic [1:0]  kIn,
    output logic [24:0] s
);

    logic        cin;
    logic [23:0] p_bit;
    logic [23:0] g_grp;
    logic [23:0] p_grp;
    logic [23:0] g_nxt;
    logic [23:0] p_nxt;
    logic [24:0] carry;

    assign cin = &kIn;

    // Prefix tree: after the last level, g_grp[i] is the carry out of bits [i:0] including cin.
    always_comb begin
        // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
        p_bit = a ^ b;
        g_grp = a & b;
        g_grp[0] = g_grp[0] | (p_bit[0] & cin);
        p_grp = p_bit;
        g_nxt = '0;
        p_nxt = '0;
        for (int lvl = 0; lvl < 5; lvl++) begin
            g_nxt = g_grp;
            p_nxt = p_grp;
            for (int i = 0; i < 24; i++) begin
                if (i >= (1 << lvl)) begin
                    g_nxt[i] = g_grp[i] | (p_grp[i] & g_grp[i - (1 << lvl)]);
                    p_nxt[i] = p_grp[i] & p_grp[i - (1 << lvl)];
                end
            end
            g_grp = g_nxt;
            p_grp = p_nxt;
        end
        carry = {g_grp, cin};
        s     = {carry[24], p_bit ^ carry[23:0]};
    end

endmodule

module mant_mul_seq #(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [23:0] op_a,
    input  logic [23:0] op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [47:0] product,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q,  state_d;
    logic [23:0] mcand_q,  mcand_d;
    logic [23:0] acc_hi_q, acc_hi_d;
    logic [23:0] acc_lo_q, acc_lo_d;
    logic [4:0]  cnt_q,    cnt_d;

    logic [23:0] add_b;
    logic [24:0] sum_s;

    // Operand gating: the multiplicand is added only when the multiplier LSB is set.
    assign add_b = acc_lo_q[0] ? mcand_q : 24'h0;

    // acc_hi + mcand is at most 2^25-2, so sum_s[24] holds the full carry.
    sum24bit u_add (
        .a   (acc_hi_q),
        .b   (add_b),
        .kIn (2'b00),
        .s   (sum_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    mcand_d  = op_a;
                    acc_hi_d = '0;
                    acc_lo_d = op_b;
                    cnt_d    = '0;
                    if (ZERO_BYPASS && ((op_a == '0) || (op_b == '0))) begin
                        acc_lo_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_hi_d = sum_s[24:1];
                acc_lo_d = {sum_s[0], acc_lo_q[23:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd23) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Asynchronous reset clears all of them.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the datapath registers are reset as well, so product reads 0 out of reset.
        if (!rstn) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge values together.
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign product     = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed and random self-checking bench for mant_mul_seq.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
// Latency is the number of rising edges after the acceptance edge until res_valid is seen.
module tb_mant_mul_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start_valid, start_ready;
    logic [23:0] op_a, op_b;
    logic        res_valid, res_ready;
    logic [47:0] product;
    logic        busy;

    logic        start_valid_nb, start_ready_nb;
    logic        res_valid_nb, res_ready_nb;
    logic [47:0] product_nb;
    logic        busy_nb;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mant_mul_seq #(.ZERO_BYPASS(1'b1)) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy)
    );

    mant_mul_seq #(.ZERO_BYPASS(1'b0)) u_dut_nb (
        .clk         (clk),
        .rstn        (rstn),
        .start_valid (start_valid_nb),
        .start_ready (start_ready_nb),
        .op_a        (op_a),
        .op_b        (op_b),
        .res_valid   (res_valid_nb),
        .res_ready   (res_ready_nb),
        .product     (product_nb),
        .busy        (busy_nb)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on the bypass-enabled instance.
    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic [47:0] exp_p, input int exp_lat,
                          input bit early_ready, input int stall);
        int w;
        int lat;
        w = 0;
        while (!start_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, " start_ready"}, 48'(start_ready), 48'd1);
        op_a        = a;
        op_b        = b;
        start_valid = 1'b1;
        res_ready   = early_ready;
        @(negedge clk);
        start_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 48'(lat), 48'(exp_lat));
        check({tag, " product"}, product, exp_p);
        if (!early_ready) begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({tag, " stall hold"}, product, exp_p);
            end
            res_ready = 1'b1;
        end
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " res_valid drop"}, 48'(res_valid), 48'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] ra, rb;
        int lat;

        rstn           = 1'b0;
        start_valid    = 1'b0;
        res_ready      = 1'b0;
        start_valid_nb = 1'b0;
        res_ready_nb   = 1'b0;
        op_a           = 24'h0;
        op_b           = 24'h0;
        repeat (3) @(negedge clk);

        check("reset start_ready", 48'(start_ready), 48'd1);
        check("reset res_valid",   48'(res_valid),   48'd0);
        check("reset busy",        48'(busy),        48'd0);
        check("reset product",     product,          48'h0);
        rstn = 1'b1;
        @(negedge clk);

        run_op("3x5",        24'd3,       24'd5,       48'h00000000000F, 24, 1'b0, 2);
        run_op("max",        24'hFFFFFF,  24'hFFFFFF,  48'hFFFFFE000001, 24, 1'b0, 0);
        run_op("1xmax",      24'h000001,  24'hFFFFFF,  48'h000000FFFFFF, 24, 1'b1, 0);
        run_op("800001x2",   24'h800001,  24'h000002,  48'h000001000002, 24, 1'b0, 1);
        run_op("abcdefx1",   24'hABCDEF,  24'h000001,  48'h000000ABCDEF, 24, 1'b1, 0);
        run_op("1000x1000",  24'h001000,  24'h001000,  48'h000001000000, 24, 1'b0, 0);
        run_op("bypass a0",  24'h000000,  24'h800000,  48'h000000000000, 0,  1'b0, 1);
        run_op("bypass b0",  24'h123456,  24'h000000,  48'h000000000000, 0,  1'b0, 0);

        // Bypass disabled: a zero operand still takes the full loop.
        op_a           = 24'h000000;
        op_b           = 24'h800000;
        start_valid_nb = 1'b1;
        @(negedge clk);
        start_valid_nb = 1'b0;
        lat = 0;
        while (!res_valid_nb && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("nobypass latency", 48'(lat), 48'd24);
        check("nobypass product", product_nb, 48'h0);
        res_ready_nb = 1'b1;
        @(negedge clk);
        res_ready_nb = 1'b0;
        check("nobypass idle", 48'(start_ready_nb), 48'd1);

        // Backpressure: start pulses during RUN and DONE must not be captured.
        op_a        = 24'h800000;
        op_b        = 24'h800000;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("bp run start_ready", 48'(start_ready), 48'd0);
        check("bp run busy",        48'(busy),        48'd1);
        op_a        = 24'h000001;
        op_b        = 24'h000001;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        lat = 6;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 48'(lat), 48'd24);
        start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp hold product", product, 48'h400000000000);
            check("bp hold valid",   48'(res_valid), 48'd1);
            @(negedge clk);
        end
        check("bp done start_ready", 48'(start_ready), 48'd0);
        check("bp done busy",        48'(busy),        48'd1);
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp release start_ready", 48'(start_ready), 48'd1);
        check("bp release busy",        48'(busy),        48'd0);
        check("bp release res_valid",   48'(res_valid),   48'd0);
        repeat (3) @(negedge clk);
        check("bp no phantom op", 48'(busy), 48'd0);

        // Reset in the middle of the loop, asserted between clock edges.
        op_a        = 24'd3;
        op_b        = 24'd5;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("midrst busy before", 48'(busy), 48'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst start_ready", 48'(start_ready), 48'd1);
        check("midrst res_valid",   48'(res_valid),   48'd0);
        check("midrst busy",        48'(busy),        48'd0);
        check("midrst product",     product,          48'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst idle after", 48'(start_ready), 48'd1);
        run_op("7x9", 24'd7, 24'd9, 48'h00000000003F, 24, 1'b0, 0);

        // Random operands with random result stalls.
        for (int k = 0; k < 1000; k++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            if (k % 97 == 5)  ra = 24'h0;
            if (k % 89 == 7)  rb = 24'h0;
            run_op("random", ra, rb, {24'h0, ra} * {24'h0, rb},
                   ((ra == 24'h0) || (rb == 24'h0)) ? 0 : 24,
                   1'b0, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
